// File: rtl/ascon_ctrl.sv
// ascon_ctrl: sequences the Ascon core phase enables for AEAD and hash jobs.
// Define ASCON_CTRL_HASH_EN to accept op=10 hash jobs with a squeeze phase.
module ascon_ctrl #(
    parameter int         FINAL_HOLD    = 2,
    parameter int         HASH_SQUEEZES = 4,
    parameter logic [1:0] SEL_AEAD      = 2'b00,
    parameter logic [1:0] SEL_HASH      = 2'b10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [31:0]  ad_len,
    input  logic [31:0]  txt_len,
    input  logic [127:0] tag_exp,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic [127:0] tag,
    output logic         auth_ok,
    output logic [1:0]   core_sel_type,
    output logic         core_mode_sel,
    output logic [31:0]  core_data_length,
    output logic [31:0]  core_data_position,
    output logic [127:0] core_data_in,
    output logic         core_en_init,
    output logic         core_en_ae_am,
    output logic         core_en_enc_dec,
    output logic         core_en_hash,
    output logic         core_en_final,
    input  logic [127:0] core_data_out,
    input  logic [127:0] core_tag
);
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_AD_WAIT, S_AD_RUN0, S_AD_RUN1,
        S_TXT_WAIT, S_TXT_RUN0, S_TXT_RUN1, S_OUT_HOLD, S_FINAL,
`ifdef ASCON_CTRL_HASH_EN
        S_SQZ0, S_SQZ1,
`endif
        S_DONE
    } state_t;

    localparam logic [7:0] FIN_LAST = 8'(FINAL_HOLD - 1);

    state_t         state_q, state_d;
    logic           dec_q, dec_d;
    logic [31:0]    ad_len_q, ad_len_d;
    logic [31:0]    txt_len_q, txt_len_d;
    logic [127:0]   tag_exp_q, tag_exp_d;
    logic [27:0]    blk_q, blk_d;
    logic [7:0]     fin_cnt_q, fin_cnt_d;
    logic [127:0]   din_q, din_d;
    logic [31:0]    dlen_q, dlen_d;
    logic [31:0]    dpos_q, dpos_d;
    logic [127:0]   out_data_q, out_data_d;
    logic           last_q, last_d;
    logic [127:0]   tag_q, tag_d;
    logic           auth_ok_q, auth_ok_d;

    logic           hash_job;
    logic           op_legal;
    logic [31:0]    ad_phase_len;
    logic [32:0]    pos_next;
    logic           ad_last;
    logic           txt_last;

`ifdef ASCON_CTRL_HASH_EN
    localparam logic [7:0] SQZ_LAST = 8'(HASH_SQUEEZES - 1);
    logic           hash_q, hash_d;
    logic           sqz_ph_q, sqz_ph_d;
    logic [7:0]     sqz_cnt_q, sqz_cnt_d;
    assign hash_job     = hash_q;
    assign op_legal     = (op != 2'b11);
    assign core_en_hash = (state_q == S_SQZ0) || (state_q == S_SQZ1);
`else
    assign hash_job     = 1'b0;
    assign op_legal     = !op[1];
    assign core_en_hash = 1'b0;
`endif

    // Hash messages ride the AD path, so their length is the message length.
    assign ad_phase_len = hash_job ? txt_len_q : ad_len_q;
    assign pos_next     = {1'b0, blk_q, 4'h0} + 33'd16;
    assign ad_last      = pos_next >= {1'b0, ad_phase_len};
    assign txt_last     = pos_next >= {1'b0, txt_len_q};

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign in_ready  = (state_q == S_AD_WAIT) || (state_q == S_TXT_WAIT);
    assign out_valid = (state_q == S_OUT_HOLD);
    assign out_last  = out_valid && last_q;
    assign out_data  = out_data_q;
    assign tag       = tag_q;
    assign auth_ok   = auth_ok_q;

    assign core_en_init    = (state_q == S_INIT);
    assign core_en_ae_am   = (state_q == S_AD_RUN0) || (state_q == S_AD_RUN1);
    assign core_en_enc_dec = (state_q == S_TXT_RUN0) || (state_q == S_TXT_RUN1);
    assign core_en_final   = (state_q == S_FINAL);

    assign core_sel_type      = hash_job ? SEL_HASH : SEL_AEAD;
    assign core_mode_sel      = dec_q;
    assign core_data_in       = din_q;
    assign core_data_length   = dlen_q;
    assign core_data_position = dpos_q;

    always_comb begin
        state_d    = state_q;
        dec_d      = dec_q;
        ad_len_d   = ad_len_q;
        txt_len_d  = txt_len_q;
        tag_exp_d  = tag_exp_q;
        blk_d      = blk_q;
        fin_cnt_d  = fin_cnt_q;
        din_d      = din_q;
        dlen_d     = dlen_q;
        dpos_d     = dpos_q;
        out_data_d = out_data_q;
        last_d     = last_q;
        tag_d      = tag_q;
        auth_ok_d  = auth_ok_q;
`ifdef ASCON_CTRL_HASH_EN
        hash_d     = hash_q;
        sqz_ph_d   = sqz_ph_q;
        sqz_cnt_d  = sqz_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && op_legal) begin
                    state_d   = S_INIT;
                    dec_d     = (op == 2'b01);
                    ad_len_d  = ad_len;
                    txt_len_d = txt_len;
                    tag_exp_d = tag_exp;
                    tag_d     = '0;
                    auth_ok_d = 1'b0;
`ifdef ASCON_CTRL_HASH_EN
                    hash_d    = (op == 2'b10);
                    sqz_ph_d  = 1'b0;
`endif
                end
            end
            S_INIT: begin
                blk_d   = '0;
                state_d = (hash_job || ad_len_q != '0) ? S_AD_WAIT : S_TXT_WAIT;
            end
            S_AD_WAIT: begin
                if (in_valid) begin
                    din_d   = in_data;
                    dlen_d  = ad_phase_len;
                    dpos_d  = {blk_q, 4'h0};
                    state_d = S_AD_RUN0;
                end
            end
            S_AD_RUN0: state_d = S_AD_RUN1;
            S_AD_RUN1: begin
                blk_d   = blk_q + 28'd1;
                state_d = S_AD_WAIT;
                if (ad_last) begin
                    blk_d   = '0;
                    state_d = S_TXT_WAIT;
`ifdef ASCON_CTRL_HASH_EN
                    if (hash_q) begin
                        sqz_cnt_d = '0;
                        sqz_ph_d  = 1'b1;
                        state_d   = S_SQZ0;
                    end
`endif
                end
            end
            S_TXT_WAIT: begin
                if (in_valid) begin
                    din_d   = in_data;
                    dlen_d  = txt_len_q;
                    dpos_d  = {blk_q, 4'h0};
                    state_d = S_TXT_RUN0;
                end
            end
            S_TXT_RUN0: state_d = S_TXT_RUN1;
            S_TXT_RUN1: begin
                out_data_d = core_data_out;
                last_d     = txt_last;
                state_d    = S_OUT_HOLD;
            end
            S_OUT_HOLD: begin
                if (out_ready) begin
                    if (last_q) begin
                        fin_cnt_d = '0;
                        state_d   = S_FINAL;
                    end else begin
                        blk_d   = blk_q + 28'd1;
                        state_d = S_TXT_WAIT;
                    end
`ifdef ASCON_CTRL_HASH_EN
                    if (sqz_ph_q) begin
                        sqz_cnt_d = sqz_cnt_q + 8'd1;
                        state_d   = last_q ? S_DONE : S_SQZ0;
                    end
`endif
                end
            end
            S_FINAL: begin
                fin_cnt_d = fin_cnt_q + 8'd1;
                if (fin_cnt_q == FIN_LAST) begin
                    tag_d     = core_tag;
                    auth_ok_d = dec_q ? (core_tag == tag_exp_q) : 1'b1;
                    state_d   = S_DONE;
                end
            end
`ifdef ASCON_CTRL_HASH_EN
            S_SQZ0: state_d = S_SQZ1;
            S_SQZ1: begin
                out_data_d = {64'h0, core_data_out[63:0]};
                last_d     = (sqz_cnt_q == SQZ_LAST);
                state_d    = S_OUT_HOLD;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dec_q      <= 1'b0;
            ad_len_q   <= '0;
            txt_len_q  <= '0;
            tag_exp_q  <= '0;
            blk_q      <= '0;
            fin_cnt_q  <= '0;
            din_q      <= '0;
            dlen_q     <= '0;
            dpos_q     <= '0;
            out_data_q <= '0;
            last_q     <= 1'b0;
            tag_q      <= '0;
            auth_ok_q  <= 1'b0;
`ifdef ASCON_CTRL_HASH_EN
            hash_q     <= 1'b0;
            sqz_ph_q   <= 1'b0;
            sqz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            ad_len_q   <= ad_len_d;
            txt_len_q  <= txt_len_d;
            tag_exp_q  <= tag_exp_d;
            blk_q      <= blk_d;
            fin_cnt_q  <= fin_cnt_d;
            din_q      <= din_d;
            dlen_q     <= dlen_d;
            dpos_q     <= dpos_d;
            out_data_q <= out_data_d;
            last_q     <= last_d;
            tag_q      <= tag_d;
            auth_ok_q  <= auth_ok_d;
`ifdef ASCON_CTRL_HASH_EN
            hash_q     <= hash_d;
            sqz_ph_q   <= sqz_ph_d;
            sqz_cnt_q  <= sqz_cnt_d;
`endif
        end
    end
endmodule

// File: doc/ascon_ctrl.md
# ascon_ctrl

Sequencer that drives the Ascon core's phase-enable interface. It accepts a job (encrypt, decrypt or optional hash), streams 128-bit host blocks into the core through a valid/ready handshake, and holds each `process_en_*` strobe for exactly the cycles the core needs. It captures ciphertext, plaintext or digest words and the tag, and reports completion. It sits between the host/bus front-end and the core, one instance per core.

## Interface
- `FINAL_HOLD`, 2: cycles `core_en_final` is held; `core_tag` is sampled on the last cycle.
- `HASH_SQUEEZES`, 4: 64-bit squeeze blocks per digest.
- `SEL_AEAD`, 2'b00: `core_sel_type` value for AEAD jobs.
- `SEL_HASH`, 2'b10: `core_sel_type` value for hash jobs.
- `clk`  in  1  clock; one clock domain, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `op`  in  2  00 encrypt, 01 decrypt, 10 hash (hash only with the macro), 11 reserved; sampled with `start`.
- `ad_len`, `txt_len`  in  32 each  byte lengths; sampled with `start`.
- `tag_exp`  in  128  expected tag for decrypt; sampled with `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 128  input block stream (AD blocks first, then text/message blocks).
- `out_valid` out 1, `out_ready` in 1, `out_data` out 128, `out_last` out 1  result stream.
- `busy` out 1, `done` out 1 (one-cycle pulse), `tag` out 128, `auth_ok` out 1.
- `core_sel_type` out 2, `core_mode_sel` out 1 (1 = decrypt), `core_data_length` out 32, `core_data_position` out 32, `core_data_in` out 128.
- `core_en_init`, `core_en_ae_am`, `core_en_enc_dec`, `core_en_hash`, `core_en_final`  out  1 each.
- `core_data_out` in 128, `core_tag` in 128.

## Operation
- States: IDLE, INIT, AD_WAIT, AD_RUN0, AD_RUN1, TXT_WAIT, TXT_RUN0, TXT_RUN1, OUT_HOLD, FINAL, SQZ0, SQZ1, DONE.
- IDLE with `start` and a legal `op` goes to INIT. `op`=11, or `op`=10 without the macro, is ignored and the block stays in IDLE. `start` outside IDLE is ignored.
- INIT: `core_en_init`=1 for one cycle. Next state is AD_WAIT if `ad_len`≠0, otherwise TXT_WAIT.
- Block counts:
  - AD: ceil(`ad_len`/16) blocks; no AD phase when `ad_len`=0.
  - Text/message: max(1, ceil(len/16)) blocks; the padding block is always issued.
- *_WAIT: `in_ready`=1. When `in_valid`&&`in_ready`, `in_data` is latched into `core_data_in` and the state moves to RUN0.
- RUN0 and RUN1: the matching enable is high on both cycles, and `core_data_in`, `core_data_length` and `core_data_position` are stable across both.
  - `core_data_length` = phase length.
  - `core_data_position` = 16 × block index (byte offset).
- TXT_RUN1 captures `core_data_out` into `out_data` and goes to OUT_HOLD.
- OUT_HOLD: `out_valid`=1. On `out_ready` it moves to the next block's WAIT state, or to FINAL after the last block. `in_ready`=0 while `out_valid` is pending.
- FINAL: `core_en_final` is held for `FINAL_HOLD` cycles. `tag` ← `core_tag` on the last cycle. `auth_ok` = (`core_tag`==`tag_exp`) for decrypt, and 1 for encrypt. Then DONE.
- DONE: `done`=1 for one cycle, then IDLE. `tag` and `auth_ok` hold until the next `start`.
- `out_last`=1 with the final text or squeeze word.
- Lengths are unsigned 32-bit. The block index is a 28-bit counter with no wrap handling; lengths ≥ 2^32−15 are unsupported.

## Timing
- Reset values: all `core_en_*`=0; `core_data_*`=0; `core_sel_type`=`SEL_AEAD`; `core_mode_sel`=0; `in_ready`=0; `out_valid`=0; `out_last`=0; `out_data`=0; `busy`=0; `done`=0; `tag`=0; `auth_ok`=0.
- `rst` mid-job: state returns to IDLE on the next edge and every enable is 0 from that cycle. No partial output is flagged.
- At most one `core_en_*` is high in any cycle, and never two adjacent RUN pairs without a WAIT cycle between them.
- `busy`=1 in every state except IDLE.
- Minimum encrypt latency from `start` (zero-wait host):
  - 1 (INIT) + 3 per AD block + 4 per text block + `FINAL_HOLD` + 1 (DONE).
  - Example: 1 AD block, 1 text block, `FINAL_HOLD`=2 → 11 cycles to `done`.

## Configuration
- `ASCON_CTRL_HASH_EN` defined: `op`=10 is legal.
  - Sequence: INIT with `core_sel_type`=`SEL_HASH`, then message blocks on `core_en_ae_am`.
  - Then `HASH_SQUEEZES` × (SQZ0, SQZ1 with `core_en_hash` high), each followed by OUT_HOLD.
  - `out_data` = {64'b0, `core_data_out[63:0]`} for each squeeze word.
  - No FINAL phase; `tag` stays 0.
- Not defined: SQZ states and the `core_en_hash` driver are absent, `core_en_hash` is tied to 0, and `op`=10 is ignored in IDLE.

## Test plan
- Encrypt, `ad_len`=16, `txt_len`=32, host always valid/ready → enable sequence init(1), ae_am(2), enc_dec(2)×2, final(2); two `out_valid` words with `out_last` on the second; `done` at cycle 15.
- Decrypt with `tag_exp` equal to `core_tag` → `auth_ok`=1; rerun with one bit flipped → `auth_ok`=0, `done` still pulses.
- `ad_len`=0, `txt_len`=0 → no ae_am cycles; exactly one enc_dec pair with `core_data_length`=0; one output word.
- `out_ready` held low 5 cycles in OUT_HOLD → `in_ready` stays 0, enables stay 0, and `out_data` is stable across all 5 cycles.
- `rst` asserted during TXT_RUN0 → next cycle all enables 0, `busy`=0, `out_valid`=0; a subsequent `start` runs a clean job.
- Hash with the macro, 16-byte message → init, ae_am pair, then 4 hash pairs; 4 output words, `out_last` on the 4th; without the macro, `op`=10 leaves `busy`=0.
